// File: rtl/fft_agu_param_if.sv
// fft_agu_param_if: controller-side command/status bus of the FFT address generation unit
interface fft_agu_param_if #(
  parameter int LOG_N = 6,
  parameter int ADDR_W = 10
);
  logic c_agu_start;
  logic [1:0] c_mode;
  logic controlIFFT;
  logic outputEnable;
  logic [ADDR_W-1:0] readAddress;
  logic x_we_ram;
  logic [LOG_N-1:0] xOpCount;
  logic [3:0] xStage;
  logic busy;
  logic done;
  modport master (
    output c_agu_start, c_mode, controlIFFT, outputEnable,
    input readAddress, x_we_ram, xOpCount, xStage, busy, done
  );
  modport slave (
    input c_agu_start, c_mode, controlIFFT, outputEnable,
    output readAddress, x_we_ram, xOpCount, xStage, busy, done
  );
endinterface

// File: rtl/fft_agu_param.sv
// fft_agu_param: radix-2 in-place FFT address generator for load, twiddle copy, butterfly and readout modes
module fft_agu_param #(
  parameter int LOG_N = 6,
  parameter int ADDR_W = 10,
  parameter int DATA_BASE = 2 << LOG_N,
  parameter int TW_BASE = 0
) (
  input logic controlPulse,
  input logic reset,
  fft_agu_param_if.slave bus,
  // kept as a plain net so the high-Z drive stays local to this module
  output wire [ADDR_W-1:0] writeAddress
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [1:0] OP_RAM = 2'd0, ROM_RAM = 2'd1, BF_RAM = 2'd2;
  localparam logic [LOG_N-1:0] HALF_N = LOG_N'(1 << (LOG_N - 1));
  localparam logic [LOG_N+1:0] TWO_N = (LOG_N+2)'(2 << LOG_N);
  localparam logic [3:0] LAST_STAGE = 4'(LOG_N - 1);
  logic [1:0] state, mode;
  logic ifft;
  logic [LOG_N+1:0] cnt;
  logic [3:0] stage, stageOut, stageNext;
  logic [LOG_N-1:0] slot, slotPrev, upR, loR, upW, loW, opCount, opNext;
  logic [LOG_N-2:0] kR;
  logic [2:0] phase;
  logic [ADDR_W-1:0] rdAddr, wrAddr, rdNext, wrNext, rdBf, wrBf;
  logic weReg, weNext, rdBfValid, weBf, lastCycle, busyReg, doneReg;
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] v);
    for (int b = 0; b < LOG_N; b++) bitrev[b] = v[LOG_N-1-b];
  endfunction
  // upper butterfly leg: insert a zero at bit position st of the slot index
  function automatic logic [LOG_N-1:0] upperOf(input logic [LOG_N-1:0] b, input logic [3:0] st);
    return ((b >> st) << (st + 4'd1)) | (b & ((LOG_N'(1) << st) - LOG_N'(1)));
  endfunction
  function automatic logic [ADDR_W-1:0] dataAddr(input logic [LOG_N-1:0] x, input logic part);
    return ADDR_W'(DATA_BASE) + ADDR_W'({x, part});
  endfunction
  function automatic logic [ADDR_W-1:0] twAddr(input logic bank, input logic [LOG_N-2:0] k, input logic part);
    return ADDR_W'(TW_BASE) + ADDR_W'({bank, k, part});
  endfunction
  // Next-cycle addresses and enables for the current mode position
  always_comb begin
    slotPrev = slot - LOG_N'(1);
    upR = upperOf(slot, stage);
    loR = upR + (LOG_N'(1) << stage);
    upW = upperOf(slotPrev, stage);
    loW = upW + (LOG_N'(1) << stage);
    kR = (LOG_N-1)'((slot & ((LOG_N'(1) << stage) - LOG_N'(1))) << (LAST_STAGE - stage));
    rdBfValid = slot != HALF_N && phase < 3'd6;
    rdBf = phase == 3'd0 ? dataAddr(loR, 1'b0) : phase == 3'd1 ? twAddr(ifft, kR, 1'b0) :
           phase == 3'd2 ? dataAddr(loR, 1'b1) : phase == 3'd3 ? twAddr(ifft, kR, 1'b1) :
           dataAddr(upR, phase[0]);
    weBf = slot != '0 && phase[2];
    wrBf = dataAddr(phase[1] ? loW : upW, phase[0]);
    lastCycle = mode == BF_RAM ? (stage == LAST_STAGE && slot == HALF_N && phase == 3'd7) :
                cnt == (mode == ROM_RAM ? TWO_N : TWO_N - (LOG_N+2)'(1));
    rdNext = rdAddr;
    wrNext = wrAddr;
    weNext = 1'b0;
    opNext = cnt[LOG_N:1];
    stageNext = 4'd0;
    case (mode)
      OP_RAM: begin
        wrNext = dataAddr(bitrev(cnt[LOG_N:1]), cnt[0]);
        weNext = 1'b1;
      end
      ROM_RAM: begin
        rdNext = cnt == TWO_N ? rdAddr : ADDR_W'(cnt);
        wrNext = cnt == '0 ? wrAddr : ADDR_W'(TW_BASE) + ADDR_W'(cnt - (LOG_N+2)'(1));
        weNext = cnt != '0;
      end
      BF_RAM: begin
        rdNext = rdBfValid ? rdBf : rdAddr;
        wrNext = weBf ? wrBf : wrAddr;
        weNext = weBf;
        opNext = slot;
        stageNext = stage;
      end
      default: rdNext = dataAddr(cnt[LOG_N:1], cnt[0]);
    endcase
  end
  // Sequencer state, position counters and registered outputs; reset wins over a coincident start
  always_ff @(posedge controlPulse) begin
    if (reset) begin
      state <= IDLE;
      mode <= OP_RAM;
      ifft <= 1'b0;
      cnt <= '0;
      stage <= '0;
      slot <= '0;
      phase <= '0;
      rdAddr <= '0;
      wrAddr <= '0;
      weReg <= 1'b0;
      opCount <= '0;
      stageOut <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      state <= state == IDLE ? (bus.c_agu_start ? RUN : IDLE) : state == RUN ? (lastCycle ? DONE : RUN) : IDLE;
      if (state == IDLE) begin
        cnt <= '0;
        stage <= '0;
        slot <= '0;
        phase <= '0;
        if (bus.c_agu_start) begin
          mode <= bus.c_mode;
          ifft <= bus.controlIFFT;
        end
      end else if (state == RUN) begin
        cnt <= cnt + (LOG_N+2)'(1);
        phase <= phase + 3'd1;
        if (phase == 3'd7) begin
          slot <= slot == HALF_N ? '0 : slot + LOG_N'(1);
          if (slot == HALF_N) stage <= stage + 4'd1;
        end
      end
      busyReg <= state == RUN;
      doneReg <= state == DONE;
      weReg <= state == RUN && weNext;
      stageOut <= state == RUN ? stageNext : 4'd0;
      if (state == RUN) begin
        rdAddr <= rdNext;
        wrAddr <= wrNext;
        opCount <= opNext;
      end
    end
  end
  assign bus.readAddress = rdAddr;
  assign bus.x_we_ram = weReg;
  assign bus.xOpCount = opCount;
  assign bus.xStage = stageOut;
  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign writeAddress = bus.outputEnable ? wrAddr : {ADDR_W{1'bz}};
endmodule

// File: tb/tb_fft_agu_param.sv
// tb_fft_agu_param: spot-vector table plus per-cycle reference model for fft_agu_param
module tb_fft_agu_param;
  localparam int LOG_N = 3, ADDR_W = 8, DB = 16, TB = 0, N = 1 << LOG_N;
  typedef struct { int run; int cyc; int ra; int wa; int we; int dn; } vec_t;
  typedef struct { int ra; int wa; int we; int op; int st; } exp_t;
  logic controlPulse = 1'b0;
  logic reset = 1'b1;
  wire [ADDR_W-1:0] writeAddress;
  int passCount = 0;
  int checkCount = 0;
  vec_t vecs[$];
  exp_t q[$];
  fft_agu_param_if #(.LOG_N(LOG_N), .ADDR_W(ADDR_W)) bus ();
  fft_agu_param #(.LOG_N(LOG_N), .ADDR_W(ADDR_W), .DATA_BASE(DB), .TW_BASE(TB)) dut (
    .controlPulse(controlPulse),
    .reset(reset),
    .bus(bus.slave),
    .writeAddress(writeAddress)
  );
  always #5 controlPulse = ~controlPulse;
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, required finish");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int req);
    checkCount++;
    if (act == req) passCount++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask
  function automatic void add(input int run, input int cyc, input int ra, input int wa, input int we, input int dn);
    vecs.push_back('{run, cyc, ra, wa, we, dn});
  endfunction
  function automatic int rev(input int x);
    int r = 0;
    for (int b = 0; b < LOG_N; b++) r = r * 2 + ((x >> b) & 1);
    return r;
  endfunction
  function automatic int upperOf(input int j, input int s);
    int half = 1 << s;
    return (j / half) * 2 * half + j % half;
  endfunction
  function automatic void buildModel(input int mode, input int ifft);
    int last = -1;
    q.delete();
    if (mode == 0) begin
      for (int i = 0; i < 2 * N; i++) q.push_back('{-1, DB + 2 * rev(i / 2) + i % 2, 1, i / 2, 0});
    end else if (mode == 1) begin
      for (int i = 0; i <= 2 * N; i++) q.push_back('{i < 2 * N ? i : -1, i >= 1 ? TB + i - 1 : -1, i >= 1 ? 1 : 0, -1, 0});
    end else if (mode == 3) begin
      for (int i = 0; i < 2 * N; i++) q.push_back('{DB + i, -1, 0, i / 2, 0});
    end else begin
      for (int s = 0; s < LOG_N; s++)
        for (int j = 0; j <= N / 2; j++)
          for (int p = 0; p < 8; p++) begin
            int half, up, lo, k, upP, loP, ra, wa, we;
            half = 1 << s;
            up = upperOf(j, s);
            lo = up + half;
            k = (j % half) * (1 << (LOG_N - 1 - s));
            ra = last;
            if (j < N / 2 && p < 6) begin
              ra = p == 0 ? DB + 2 * lo : p == 1 ? TB + ifft * N + 2 * k : p == 2 ? DB + 2 * lo + 1 :
                   p == 3 ? TB + ifft * N + 2 * k + 1 : p == 4 ? DB + 2 * up : DB + 2 * up + 1;
              last = ra;
            end
            wa = -1;
            we = 0;
            if (j > 0 && p >= 4) begin
              upP = upperOf(j - 1, s);
              loP = upP + half;
              we = 1;
              wa = p == 4 ? DB + 2 * upP : p == 5 ? DB + 2 * upP + 1 : p == 6 ? DB + 2 * loP : DB + 2 * loP + 1;
            end
            q.push_back('{ra, wa, we, j, s});
          end
    end
  endfunction
  function automatic logic pickOe(input int oeSel);
    return oeSel == 0 ? 1'b1 : oeSel == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  endfunction
  task automatic checkReset(input string tag);
    check({tag, "_readAddress"}, bus.readAddress, 0);
    check({tag, "_writeAddress"}, writeAddress, 0);
    check({tag, "_we"}, bus.x_we_ram, 0);
    check({tag, "_xOpCount"}, bus.xOpCount, 0);
    check({tag, "_xStage"}, bus.xStage, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask
  task automatic runMode(input int mode, input int ifft, input int runId, input int oeSel, input bit noise);
    int len;
    exp_t e;
    buildModel(mode, ifft);
    len = q.size();
    bus.c_mode = 2'(mode);
    bus.controlIFFT = ifft[0];
    bus.outputEnable = pickOe(oeSel);
    bus.c_agu_start = 1'b1;
    @(posedge controlPulse);
    #1;
    bus.c_agu_start = 1'b0;
    for (int c = 1; c <= len + 2; c++) begin
      @(posedge controlPulse);
      #1;
      if (c <= len) begin
        e = q[c-1];
        check("busy", bus.busy, 1);
        check("done", bus.done, 0);
        check("we", bus.x_we_ram, e.we);
        if (e.ra >= 0) check("readAddress", bus.readAddress, e.ra);
        if (e.we == 1) begin
          if (bus.outputEnable) check("writeAddress", writeAddress, e.wa);
          else if (e.wa != 0) check("hiZ", int'(writeAddress !== ADDR_W'(e.wa)), 1);
        end
        if (e.op >= 0) check("xOpCount", bus.xOpCount, e.op);
        check("xStage", bus.xStage, e.st);
      end else begin
        check("doneEnd", bus.done, int'(c == len + 1));
        check("busyEnd", bus.busy, 0);
        check("weEnd", bus.x_we_ram, 0);
      end
      foreach (vecs[v]) if (vecs[v].run == runId && vecs[v].cyc == c) begin
        if (vecs[v].ra >= 0) check("vecReadAddress", bus.readAddress, vecs[v].ra);
        if (vecs[v].wa >= 0) check("vecWriteAddress", writeAddress, vecs[v].wa);
        if (vecs[v].we >= 0) check("vecWe", bus.x_we_ram, vecs[v].we);
        if (vecs[v].dn >= 0) check("vecDone", bus.done, vecs[v].dn);
      end
      if (noise && c <= len) begin
        bus.c_agu_start = 1'($urandom_range(0, 1));
        bus.c_mode = 2'($urandom_range(0, 3));
        bus.controlIFFT = 1'($urandom_range(0, 1));
      end else bus.c_agu_start = 1'b0;
      bus.outputEnable = pickOe(oeSel);
    end
    bus.outputEnable = 1'b1;
  endtask
  initial begin
    for (int c = 1; c <= 10; c++) add(0, c, -1, DB + 2 * rev((c - 1) / 2) + (c - 1) % 2, 1, 0);
    add(0, 3, -1, 24, 1, 0); add(0, 5, -1, 20, 1, 0); add(0, 9, -1, 18, 1, 0);
    add(0, 16, -1, 31, 1, 0); add(0, 17, -1, -1, 0, 1);
    add(1, 1, 0, -1, 0, 0); add(1, 2, 1, 0, 1, 0); add(1, 16, 15, 14, 1, 0);
    add(1, 17, -1, 15, 1, 0); add(1, 18, -1, -1, 0, 1);
    add(2, 1, 18, -1, 0, 0); add(2, 2, 0, -1, 0, 0); add(2, 3, 19, -1, 0, 0);
    add(2, 4, 1, -1, 0, 0); add(2, 5, 16, -1, 0, 0); add(2, 6, 17, -1, 0, 0);
    add(2, 7, -1, -1, 0, 0); add(2, 8, -1, -1, 0, 0);
    add(2, 13, -1, 16, 1, 0); add(2, 14, -1, 17, 1, 0); add(2, 15, -1, 18, 1, 0); add(2, 16, -1, 19, 1, 0);
    add(3, 105, 30, -1, 0, 0); add(3, 106, 14, -1, 0, 0); add(3, 107, 31, -1, 0, 0);
    add(3, 108, 15, -1, 0, 0); add(3, 109, 22, -1, -1, 0); add(3, 110, 23, -1, -1, 0);
    add(3, 117, -1, 22, 1, 0); add(3, 118, -1, 23, 1, 0); add(3, 119, -1, 30, 1, 0);
    add(3, 120, -1, 31, 1, 0); add(3, 121, -1, -1, 0, 1);
    bus.c_agu_start = 1'b0;
    bus.c_mode = 2'd0;
    bus.controlIFFT = 1'b0;
    bus.outputEnable = 1'b1;
    repeat (2) @(posedge controlPulse);
    #1;
    checkReset("reset");
    reset = 1'b0;
    runMode(0, 0, 0, 0, 1'b0);
    runMode(1, 0, 1, 0, 1'b0);
    runMode(2, 0, 2, 0, 1'b0);
    runMode(2, 1, 3, 0, 1'b0);
    runMode(0, 0, 4, 1, 1'b1);
    runMode(3, 0, 5, 0, 1'b0);
    bus.c_mode = 2'd2;
    bus.c_agu_start = 1'b1;
    @(posedge controlPulse);
    #1;
    bus.c_agu_start = 1'b0;
    repeat (52) @(posedge controlPulse);
    #1;
    check("midStage", bus.xStage, 1);
    reset = 1'b1;
    @(posedge controlPulse);
    #1;
    checkReset("midReset");
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge controlPulse);
      #1;
      check("idleAfterReset_busy", bus.busy, 0);
      check("idleAfterReset_we", bus.x_we_ram, 0);
    end
    runMode(2, 0, 2, 0, 1'b0);
    reset = 1'b1;
    bus.c_mode = 2'd1;
    bus.c_agu_start = 1'b1;
    @(posedge controlPulse);
    #1;
    reset = 1'b0;
    bus.c_agu_start = 1'b0;
    for (int r = 0; r < 3; r++) begin
      @(posedge controlPulse);
      #1;
      check("startUnderReset_busy", bus.busy, 0);
      check("startUnderReset_done", bus.done, 0);
    end
    repeat (12) runMode(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), -1, 2, 1'b1);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/fft_agu_param.md
# fft_agu_param

Parametrised address generation unit for the radix-2 in-place FFT/IFFT core. It generates RAM/ROM read and write addresses, with write-enable, for the four data-movement modes: bit-reversed input load, twiddle ROM-to-RAM copy, butterfly sequencing and natural-order readout. Butterfly, stage and twiddle indices are computed internally for any N = 2^LOG_N. The unit runs each mode to completion and reports `done`, so the controller only issues a start pulse and a mode.

## Interface
- LOG_N, 6: log2 of FFT points; N = 2^LOG_N, 3 ≤ LOG_N ≤ 12.
- ADDR_W, 10: RAM/ROM address width; must hold DATA_BASE+2N-1 and TW_BASE+2N-1.
- DATA_BASE, 2N: word address of sample region (2N words, re at even, im at odd).
- TW_BASE, 0: word address of twiddle region (2N words: FFT bank then IFFT bank).

- controlPulse  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high; returns unit to IDLE.
- c_agu_start  in  1  single-cycle start strobe; sampled only in IDLE.
- c_mode  in  2  0 OP_RAM, 1 ROM_RAM, 2 BF_RAM, 3 RAM_OP; latched with start.
- controlIFFT  in  1  twiddle bank select; latched with start.
- outputEnable  in  1  1: drive writeAddress; 0: writeAddress high-Z.
- readAddress  out  ADDR_W  registered read address.
- writeAddress  out  ADDR_W  registered write address, tristated by outputEnable.
- x_we_ram  out  1  registered RAM write enable, aligned with writeAddress.
- xOpCount  out  LOG_N  current sample/butterfly index.
- xStage  out  4  current butterfly stage (BF_RAM), else 0.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DONE. IDLE→RUN on c_agu_start (modes 0–3 all valid). RUN→DONE after the last mode cycle. DONE→IDLE after 1 cycle, with done=1 during DONE.
- Internal counter i counts mode cycles from 0.
- OP_RAM (2N cycles): writeAddress = DATA_BASE + {bitrev_LOG_N(i>>1), i[0]}; x_we_ram=1; xOpCount=i>>1.
- ROM_RAM (2N+1 cycles): readAddress = i for i<2N. writeAddress = TW_BASE + (i-1) with x_we_ram=1 for 1≤i≤2N (ROM latency 1).
- RAM_OP (2N cycles): readAddress = DATA_BASE + i; x_we_ram=0; xOpCount=i>>1.
- BF_RAM: stages s=0..LOG_N-1. Each stage has N/2 butterfly slots j plus one drain slot. Every slot is 8 cycles (phase p=0..7).
  - half=1<<s; upper = ((j>>s)<<(s+1)) + (j&(half-1)); lower = upper+half; k = (j&(half-1))<<(LOG_N-1-s).
  - Data address D(x,part) = DATA_BASE + 2x + part.
  - Twiddle address T(part) = TW_BASE + {ifft, k[LOG_N-2:0], part}.
  - Reads by phase: p0 D(lower,0), p1 T(0), p2 D(lower,1), p3 T(1), p4 D(upper,0), p5 D(upper,1). p6–7 hold.
  - Writes for the previous butterfly in the same stage: p4 D(upper',0), p5 D(upper',1), p6 D(lower',0), p7 D(lower',1), with x_we_ram=1 on those phases only.
  - Slot j=0 of each stage writes nothing. The drain slot issues writes only; readAddress holds.
  - xOpCount=j; xStage=s.
- Address arithmetic is modulo 2^ADDR_W. Exceeding it is a parameter error and is not checked.

## Timing
- Reset values: readAddress 0, writeAddress 0 (or Z if outputEnable=0), x_we_ram 0, xOpCount 0, xStage 0, busy 0, done 0.
- Start sampled at edge t. First address/enable is valid after edge t+1; busy rises at t+1.
- Cycle counts: OP_RAM 2N, ROM_RAM 2N+1, RAM_OP 2N, BF_RAM LOG_N·(N/2+1)·8.
- done is high the cycle after the last mode cycle. busy falls the same cycle. x_we_ram is 0 in DONE.
- c_agu_start while RUN/DONE is ignored. Mode and controlIFFT changes during RUN are ignored.
- Reset during any state forces reset values at the next edge. No partial write is issued after that edge.
- Start coincident with reset: reset wins.
- outputEnable affects only the writeAddress drive, never the internal state.

## Test plan
- LOG_N=3, DATA_BASE=16, OP_RAM start → writeAddress 16,17,24,25,20,21,28,29,18,19,… with x_we_ram=1 for 16 cycles, done at start+17.
- ROM_RAM, TW_BASE=0 → readAddress 0..15, writeAddress 0..15 one cycle later. done after 17 mode cycles.
- BF_RAM, controlIFFT=0, stage 0 slot 0 → reads 18,0,19,1,16,17, no writes. Slot 1 phases 4–7 → writes 16,17,18,19.
- BF_RAM, controlIFFT=1, stage 2 slot 3 → reads 30,14,31,15,22,23. The following drain slot writes 22,23,30,31. done at start+121.
- Reset asserted mid BF_RAM stage 1 → next edge: all outputs at reset values, IDLE. A new start then begins at stage 0, slot 0.
- Start pulse during RUN, and outputEnable=0 → run length unchanged, writeAddress reads Z, x_we_ram still toggles.
